// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM states, detector patterns and detector output codes
// for the serial pattern transmitter and its detector reference model.
package serial_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [2:0] PAT_A = 3'b111;
    localparam logic [2:0] PAT_B = 3'b001;
    localparam logic [1:0] MATCH = 2'b10;
    localparam logic [1:0] NO_MATCH = 2'b00;
endpackage

// File: rtl/serial_pattern_model.sv
// serial_pattern_model: reference 3-bit-window detector (111 / 001) with a
// saturating match counter; the window persists across word boundaries.
module serial_pattern_model
    import serial_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [1:0] exp,
    output logic [7:0] match_cnt
);
    logic [2:0] window;
    logic [2:0] next_win;
    logic       hit;

    assign next_win = {window[1:0], bit_in};
    assign hit = (next_win == PAT_A) || (next_win == PAT_B);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window    <= '0;
            exp       <= NO_MATCH;
            match_cnt <= '0;
        end else if (bit_valid) begin
            window <= next_win;
            exp    <= hit ? MATCH : NO_MATCH;
            if (hit && match_cnt != 8'hFF)
                match_cnt <= match_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first parallel-to-serial transmitter with gapless
// back-to-back words; SERIAL_PATTERN_MODEL_EN adds the detector reference model.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int   WIDTH      = 10,
    parameter int   LEN_W      = $clog2(WIDTH + 1),
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
`ifdef SERIAL_PATTERN_MODEL_EN
    ,
    output logic [1:0]       exp,
    output logic [7:0]       match_cnt
`endif
);
    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, aligned;
    logic [LEN_W-1:0] cnt, cnt_n, eff_len;
    logic             o_n, valid_n, done_n, accept;

    // Left-justify the word so the first bit to send always sits at the MSB.
    assign eff_len = (load_len == '0 || load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
    assign aligned = load_data << (LEN_W'(WIDTH) - eff_len);
    assign load_ready = (state == IDLE) || (cnt == LEN_W'(1));
    assign accept = load_valid && load_ready;
    assign busy = (state == SHIFT);

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        o_n     = IDLE_LEVEL;
        valid_n = 1'b0;
        done_n  = 1'b0;
        if (accept) begin
            state_n = SHIFT;
            o_n     = aligned[WIDTH-1];
            sreg_n  = aligned << 1;
            cnt_n   = eff_len;
            valid_n = 1'b1;
            done_n  = (eff_len == LEN_W'(1));
        end else if (state == SHIFT && cnt > LEN_W'(1)) begin
            o_n     = sreg[WIDTH-1];
            sreg_n  = sreg << 1;
            cnt_n   = cnt - LEN_W'(1);
            valid_n = 1'b1;
            done_n  = (cnt == LEN_W'(2));
        end else if (state == SHIFT) begin
            state_n = IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            o       <= IDLE_LEVEL;
            o_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cnt     <= cnt_n;
            o       <= o_n;
            o_valid <= valid_n;
            done    <= done_n;
        end
    end

`ifdef SERIAL_PATTERN_MODEL_EN
    serial_pattern_model u_model (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (o),
        .bit_valid (o_valid),
        .exp       (exp),
        .match_cnt (match_cnt)
    );
`endif
endmodule
